// File: rtl/ad7616_parallel_responder.sv
// ad7616_parallel_responder
//   Device-side model of the AD7616 parallel bus. It answers cnvst with a timed busy
//   pulse, returns deterministic sample words on read strobes, and holds a 64 x 9-bit
//   register file that the host can write and read back.
//
// Ports
//   sys_clk     single clock for all logic
//   reset       synchronous, active-high reset
//   rx_cnvst    conversion start from host
//   rx_busy     conversion in progress
//   rx_cs_n     chip select, active low
//   rx_rd_n     read strobe, active low
//   rx_wr_n     write strobe, active low
//   rx_db_o     host-driven data bus (write data)
//   rx_db_t     host tristate, 1 = host is reading
//   rx_db_i     responder-driven data bus (read data)
//   db_drive    responder is driving rx_db_i
//   overrun     one-cycle pulse, cnvst edge ignored during a conversion
//   read_err    one-cycle pulse, sample read while converting
//   conv_count  completed conversions, wraps at 16'hFFFF

module ad7616_parallel_responder #(
   parameter int unsigned BUSY_CYCLES       = 100,
   parameter int unsigned CHANNELS_PER_CONV = 2
) (
   input  logic        sys_clk,
   input  logic        reset,
   input  logic        rx_cnvst,
   output logic        rx_busy,
   input  logic        rx_cs_n,
   input  logic        rx_rd_n,
   input  logic        rx_wr_n,
   input  logic [15:0] rx_db_o,
   input  logic        rx_db_t,
   output logic [15:0] rx_db_i,
   output logic        db_drive,
   output logic        overrun,
   output logic        read_err,
   output logic [15:0] conv_count
);

   typedef enum logic [1:0] {StIdle, StConv, StReady} state_e;

   localparam logic [15:0] BusyLoad = 16'(BUSY_CYCLES - 1);
   localparam logic [3:0]  PtrLast  = 4'(CHANNELS_PER_CONV - 1);

   // Two-stage input capture; q1 is the newer sample.
   logic cnvst_q1, cnvst_q2;
   logic cs_q1, cs_q2;
   logic rd_q1, rd_q2;
   logic wr_q1, wr_q2;

   logic [15:0] wdata_q;

   state_e      state_q, state_d;
   logic [15:0] busy_cnt_q, busy_cnt_d;
   logic [3:0]  ptr_q, ptr_d;
   logic        armed_q, armed_d;
   logic [5:0]  arm_addr_q, arm_addr_d;
   logic [8:0]  regs_q [64];
   logic [8:0]  regs_d [64];
   logic        rx_busy_q, rx_busy_d;
   logic [15:0] rx_db_i_q, rx_db_i_d;
   logic        db_drive_q, db_drive_d;
   logic        overrun_q, overrun_d;
   logic        read_err_q, read_err_d;
   logic [15:0] conv_count_q, conv_count_d;

   logic        cnvst_rise, rd_fall, rd_rise, cs_rise, wr_rise;
   logic        wr_ok, read_ok;
   logic [11:0] conv_idx;

   always_comb begin
      cnvst_rise = cnvst_q1 & ~cnvst_q2;
      rd_fall    = ~rd_q1 & rd_q2;
      rd_rise    = rd_q1 & ~rd_q2;
      cs_rise    = cs_q1 & ~cs_q2;
      wr_rise    = wr_q1 & ~wr_q2;
      // cs must have been low while wr was low, and rd must not overlap the write pulse.
      wr_ok      = wr_rise & ~cs_q2 & rd_q2;
      read_ok    = rd_fall & ~cs_q1;
      // In READY conv_count has already been bumped; samples carry the pre-increment index.
      conv_idx   = conv_count_q[11:0] - 12'd1;

      state_d      = state_q;
      busy_cnt_d   = busy_cnt_q;
      ptr_d        = ptr_q;
      armed_d      = armed_q;
      arm_addr_d   = arm_addr_q;
      regs_d       = regs_q;
      rx_busy_d    = rx_busy_q;
      rx_db_i_d    = rx_db_i_q;
      db_drive_d   = db_drive_q;
      overrun_d    = 1'b0;
      read_err_d   = 1'b0;
      conv_count_d = conv_count_q;

      // Write is handled before the read so a same-cycle arm applies to that read.
      if (wr_ok) begin
         if (wdata_q[15]) begin
            regs_d[wdata_q[14:9]] = wdata_q[8:0];
         end else begin
            armed_d    = 1'b1;
            arm_addr_d = wdata_q[14:9];
         end
      end

      if (read_ok) begin
         db_drive_d = 1'b1;
         if (armed_d) begin
            rx_db_i_d = {1'b0, arm_addr_d, regs_d[arm_addr_d]};
            armed_d   = 1'b0;
         end else begin
            unique case (state_q)
               StReady: begin
                  rx_db_i_d = {ptr_q, conv_idx};
                  ptr_d     = (ptr_q == PtrLast) ? 4'd0 : ptr_q + 4'd1;
               end
               StConv: begin
                  rx_db_i_d  = 16'h0000;
                  read_err_d = 1'b1;
               end
               default: rx_db_i_d = 16'h0000;
            endcase
         end
      end
      if (rd_rise || cs_rise || !rx_db_t) begin
         db_drive_d = 1'b0;
      end

      // Conversion FSM; placed last so a new conversion's pointer reset wins.
      unique case (state_q)
         StConv: begin
            if (cnvst_rise) begin
               overrun_d = 1'b1;
            end
            if (busy_cnt_q == 16'd0) begin
               rx_busy_d    = 1'b0;
               conv_count_d = conv_count_q + 16'd1;
               state_d      = StReady;
            end else begin
               busy_cnt_d = busy_cnt_q - 16'd1;
            end
         end
         default: begin
            if (cnvst_rise) begin
               state_d    = StConv;
               rx_busy_d  = 1'b1;
               busy_cnt_d = BusyLoad;
               ptr_d      = 4'd0;
            end
         end
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         cnvst_q1     <= 1'b0;
         cnvst_q2     <= 1'b0;
         cs_q1        <= 1'b1;
         cs_q2        <= 1'b1;
         rd_q1        <= 1'b1;
         rd_q2        <= 1'b1;
         wr_q1        <= 1'b1;
         wr_q2        <= 1'b1;
         wdata_q      <= 16'h0000;
         state_q      <= StIdle;
         busy_cnt_q   <= 16'd0;
         ptr_q        <= 4'd0;
         armed_q      <= 1'b0;
         arm_addr_q   <= 6'd0;
         for (int i = 0; i < 64; i++) begin
            regs_q[i] <= 9'd0;
         end
         rx_busy_q    <= 1'b0;
         rx_db_i_q    <= 16'h0000;
         db_drive_q   <= 1'b0;
         overrun_q    <= 1'b0;
         read_err_q   <= 1'b0;
         conv_count_q <= 16'd0;
      end else begin
         cnvst_q1     <= rx_cnvst;
         cnvst_q2     <= cnvst_q1;
         cs_q1        <= rx_cs_n;
         cs_q2        <= cs_q1;
         rd_q1        <= rx_rd_n;
         rd_q2        <= rd_q1;
         wr_q1        <= rx_wr_n;
         wr_q2        <= wr_q1;
         // Hold the last bus value seen while wr_n was low.
         if (!rx_wr_n) begin
            wdata_q <= rx_db_o;
         end
         state_q      <= state_d;
         busy_cnt_q   <= busy_cnt_d;
         ptr_q        <= ptr_d;
         armed_q      <= armed_d;
         arm_addr_q   <= arm_addr_d;
         regs_q       <= regs_d;
         rx_busy_q    <= rx_busy_d;
         rx_db_i_q    <= rx_db_i_d;
         db_drive_q   <= db_drive_d;
         overrun_q    <= overrun_d;
         read_err_q   <= read_err_d;
         conv_count_q <= conv_count_d;
      end
   end

   assign rx_busy    = rx_busy_q;
   assign rx_db_i    = rx_db_i_q;
   assign db_drive   = db_drive_q;
   assign overrun    = overrun_q;
   assign read_err   = read_err_q;
   assign conv_count = conv_count_q;

endmodule

// File: tb/tb_ad7616_parallel_responder.sv
// Bench for ad7616_parallel_responder: bus-level stimulus, inputs driven and outputs
// sampled on the falling clock edge, expected values from a transaction-level model.

module tb_ad7616_parallel_responder;

   localparam int BUSY = 100;
   localparam int CH   = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cnvst = 1'b0;
   logic        cs_n = 1'b1;
   logic        rd_n = 1'b1;
   logic        wr_n = 1'b1;
   logic [15:0] db_o = 16'h0000;
   logic        db_t = 1'b1;
   logic        busy;
   logic [15:0] db_i;
   logic        db_drive;
   logic        overrun;
   logic        read_err;
   logic [15:0] conv_count;

   int total = 0;
   int bad   = 0;
   int ovr_cnt  = 0;
   int rerr_cnt = 0;

   // Transaction-level model state.
   logic [8:0]  m_regs [64];
   logic        m_armed;
   logic [5:0]  m_addr;
   logic        m_ready;
   int          m_ptr;
   logic [15:0] m_count;
   logic [15:0] m_n;

   ad7616_parallel_responder #(
      .BUSY_CYCLES       (BUSY),
      .CHANNELS_PER_CONV (CH)
   ) dut (
      .sys_clk    (clk),
      .reset      (rst),
      .rx_cnvst   (cnvst),
      .rx_busy    (busy),
      .rx_cs_n    (cs_n),
      .rx_rd_n    (rd_n),
      .rx_wr_n    (wr_n),
      .rx_db_o    (db_o),
      .rx_db_t    (db_t),
      .rx_db_i    (db_i),
      .db_drive   (db_drive),
      .overrun    (overrun),
      .read_err   (read_err),
      .conv_count (conv_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (overrun === 1'b1) ovr_cnt++;
      if (read_err === 1'b1) rerr_cnt++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end

   // ---------------- model ----------------
   task automatic m_reset();
      for (int i = 0; i < 64; i++) m_regs[i] = 9'd0;
      m_armed = 1'b0; m_addr = 6'd0; m_ready = 1'b0; m_ptr = 0;
      m_count = 16'd0; m_n = 16'd0;
   endtask

   task automatic m_write(input logic [15:0] w);
      if (w[15]) m_regs[w[14:9]] = w[8:0];
      else begin m_armed = 1'b1; m_addr = w[14:9]; end
   endtask

   task automatic m_conv();
      m_n = m_count; m_count = m_count + 16'd1; m_ptr = 0; m_ready = 1'b1;
   endtask

   function automatic logic [15:0] m_read();
      logic [15:0] w;
      logic [3:0]  c;
      if (m_armed) begin
         m_armed = 1'b0;
         return {1'b0, m_addr, m_regs[m_addr]};
      end
      if (!m_ready) return 16'h0000;
      c = 4'(m_ptr);
      w = {c, m_n[11:0]};
      m_ptr = (m_ptr + 1) % CH;
      return w;
   endfunction

   // ---------------- bus helpers (stimulus only) ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic [15:0] w);
      cs_n = 1'b0; db_o = w; wr_n = 1'b0; cyc(3);
      wr_n = 1'b1; cyc(3);
      cs_n = 1'b1; cyc(3);
      m_write(w);
   endtask

   task automatic bus_read(output logic [15:0] d, output logic drv_on, output logic drv_off);
      cs_n = 1'b0; rd_n = 1'b0; cyc(3);
      d = db_i; drv_on = db_drive;
      rd_n = 1'b1; cyc(3);
      drv_off = db_drive;
      cs_n = 1'b1; cyc(3);
   endtask

   task automatic run_conv(output int len);
      len = 0;
      cnvst = 1'b1;
      for (int k = 0; k < 3 * BUSY + 20; k++) begin
         cyc(1);
         if (k == 2) cnvst = 1'b0;
         if (busy === 1'b1) len++;
         else if (len > 0) break;
      end
      cnvst = 1'b0;
      m_conv();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [15:0] d, e;
      logic on, off;
      int re0;
      rst = 1'b1; cyc(3); rst = 1'b0; cyc(1);
      m_reset();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (db_i !== 16'h0) begin bad++; $display("FAIL reset_db_i: got %h want 0000", db_i); end
      total++; if (db_drive !== 1'b0) begin bad++; $display("FAIL reset_drive: got %b want 0", db_drive); end
      total++; if (overrun !== 1'b0 || read_err !== 1'b0) begin
         bad++; $display("FAIL reset_pulses: got ovr=%b rerr=%b want 0 0", overrun, read_err); end
      total++; if (conv_count !== 16'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", conv_count); end
      re0 = rerr_cnt;
      bus_read(d, on, off); e = m_read();
      total++; if (d !== e) begin bad++; $display("FAIL idle_read: got %h want %h", d, e); end
      total++; if (on !== 1'b1 || off !== 1'b0) begin
         bad++; $display("FAIL idle_drive: got on=%b off=%b want 1 0", on, off); end
      total++; if (rerr_cnt != re0) begin bad++; $display("FAIL idle_read_err: got %0d pulses want 0", rerr_cnt - re0); end
   endtask

   task automatic test_conversion();
      int len;
      cnvst = 1'b1; cyc(1);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_early: got %b want 0", busy); end
      cyc(1);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_rise: got %b want 1", busy); end
      cnvst = 1'b0;
      len = 1;
      for (int k = 0; k < 3 * BUSY; k++) begin
         cyc(1);
         if (busy === 1'b1) len++; else break;
      end
      m_conv();
      total++; if (len != BUSY) begin bad++; $display("FAIL busy_len: got %0d want %0d", len, BUSY); end
      total++; if (conv_count !== m_count) begin
         bad++; $display("FAIL conv_count1: got %0d want %0d", conv_count, m_count); end
   endtask

   task automatic test_sample_reads();
      logic [15:0] d, e;
      logic on, off;
      int len;
      for (int i = 0; i < 3; i++) begin
         bus_read(d, on, off); e = m_read();
         total++; if (d !== e) begin bad++; $display("FAIL sample_read%0d: got %h want %h", i, d, e); end
      end
      while (m_count <= 16'd5) begin
         run_conv(len);
         total++; if (len != BUSY) begin bad++; $display("FAIL conv_len: got %0d want %0d", len, BUSY); end
      end
      for (int i = 0; i < 2; i++) begin
         bus_read(d, on, off); e = m_read();
         total++; if (d !== e) begin bad++; $display("FAIL sample5_read%0d: got %h want %h", i, d, e); end
      end
      total++; if (conv_count !== m_count) begin
         bad++; $display("FAIL conv_count6: got %0d want %0d", conv_count, m_count); end
   endtask

   task automatic test_register();
      logic [15:0] d, e, w;
      logic on, off;
      int len, op, re0;
      bus_write(16'h8A55);
      bus_write(16'h0A00);
      bus_read(d, on, off); e = m_read();
      total++; if (d !== e) begin bad++; $display("FAIL readback_a55: got %h want %h", d, e); end
      bus_read(d, on, off); e = m_read();
      total++; if (d !== e) begin bad++; $display("FAIL post_readback_sample: got %h want %h", d, e); end
      re0 = rerr_cnt;
      for (int it = 0; it < 30; it++) begin
         op = int'($urandom_range(0, 4));
         if (op <= 1) begin
            w = {1'b1, 15'($urandom)};
            bus_write(w);
         end else if (op == 2) begin
            w = {1'b0, 6'($urandom), 9'($urandom)};
            bus_write(w);
            bus_read(d, on, off); e = m_read();
            total++; if (d !== e) begin bad++; $display("FAIL rand_readback%0d: got %h want %h", it, d, e); end
         end else if (op == 3) begin
            bus_read(d, on, off); e = m_read();
            total++; if (d !== e || on !== 1'b1 || off !== 1'b0) begin
               bad++; $display("FAIL rand_read%0d: got %h/%b%b want %h/10", it, d, on, off, e); end
         end else begin
            run_conv(len);
            total++; if (len != BUSY || conv_count !== m_count) begin
               bad++; $display("FAIL rand_conv%0d: got len=%0d cnt=%0d want %0d %0d",
                               it, len, conv_count, BUSY, m_count); end
         end
      end
      total++; if (rerr_cnt != re0) begin bad++; $display("FAIL rand_read_err: got %0d want 0", rerr_cnt - re0); end
   endtask

   task automatic test_overrun_conv_read();
      int ovr0, re0, len;
      logic [15:0] rdv;
      ovr0 = ovr_cnt; re0 = rerr_cnt; len = 0; rdv = 16'hFFFF;
      for (int t = 0; t < BUSY + 40; t++) begin
         cnvst = (t < 3) || (t >= 20 && t < 23);
         cs_n  = !(t >= 40 && t < 46);
         rd_n  = !(t >= 40 && t < 46);
         if (t == 44) rdv = db_i;
         if (busy === 1'b1) len++;
         cyc(1);
      end
      m_conv();
      total++; if (len != BUSY) begin bad++; $display("FAIL ovr_busy_len: got %0d want %0d", len, BUSY); end
      total++; if (ovr_cnt - ovr0 != 1) begin bad++; $display("FAIL overrun_pulses: got %0d want 1", ovr_cnt - ovr0); end
      total++; if (rerr_cnt - re0 != 1) begin bad++; $display("FAIL read_err_pulses: got %0d want 1", rerr_cnt - re0); end
      total++; if (rdv !== 16'h0000) begin bad++; $display("FAIL conv_read_data: got %h want 0000", rdv); end
      total++; if (conv_count !== m_count) begin
         bad++; $display("FAIL ovr_conv_count: got %0d want %0d", conv_count, m_count); end
   endtask

   task automatic test_reset_mid_conv();
      logic [15:0] d, e;
      logic on, off;
      cnvst = 1'b1; cyc(2); cnvst = 1'b0; cyc(48);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL midconv_busy: got %b want 1", busy); end
      rst = 1'b1; cyc(1);
      total++; if (busy !== 1'b0 || conv_count !== 16'd0 || db_i !== 16'h0 || db_drive !== 1'b0) begin
         bad++; $display("FAIL midconv_reset: got busy=%b cnt=%0d db=%h drv=%b want 0 0 0000 0",
                         busy, conv_count, db_i, db_drive); end
      rst = 1'b0; cyc(2);
      m_reset();
      bus_write(16'h0A00);
      bus_read(d, on, off); e = m_read();
      total++; if (d !== e) begin bad++; $display("FAIL reset_readback: got %h want %h", d, e); end
   endtask

   task automatic test_simultaneous();
      logic [15:0] w, d, e;
      logic on, off;
      int len;
      // cnvst rising together with a register write.
      w = {1'b1, 6'd9, 9'($urandom)};
      cs_n = 1'b0; db_o = w; wr_n = 1'b0; cyc(3);
      wr_n = 1'b1; cnvst = 1'b1; cyc(1);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL sim_busy_early: got %b want 0", busy); end
      cyc(1);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL sim_busy_rise: got %b want 1", busy); end
      cnvst = 1'b0; cs_n = 1'b1; len = 1;
      for (int k = 0; k < 3 * BUSY; k++) begin
         cyc(1);
         if (busy === 1'b1) len++; else break;
      end
      m_write(w); m_conv();
      total++; if (len != BUSY) begin bad++; $display("FAIL sim_busy_len: got %0d want %0d", len, BUSY); end
      // Readback arm on wr rising in the same cycle as rd falling.
      w = {1'b0, 6'd9, 9'd0};
      cs_n = 1'b0; db_o = w; wr_n = 1'b0; cyc(3);
      wr_n = 1'b1; rd_n = 1'b0; cyc(3);
      d = db_i; m_write(w); e = m_read();
      rd_n = 1'b1; cyc(3); cs_n = 1'b1; cyc(3);
      total++; if (d !== e) begin bad++; $display("FAIL sim_arm_read: got %h want %h", d, e); end
      // A write pulse inside a read is ignored.
      cs_n = 1'b0; rd_n = 1'b0; cyc(3);
      d = db_i; e = m_read();
      total++; if (d !== e) begin bad++; $display("FAIL overlap_read: got %h want %h", d, e); end
      db_o = {1'b1, 6'd9, ~m_regs[9]}; wr_n = 1'b0; cyc(3);
      wr_n = 1'b1; cyc(3); rd_n = 1'b1; cyc(3); cs_n = 1'b1; cyc(3);
      bus_write({1'b0, 6'd9, 9'd0});
      bus_read(d, on, off); e = m_read();
      total++; if (d !== e) begin bad++; $display("FAIL overlap_write_ignored: got %h want %h", d, e); end
   endtask

   task automatic test_db_release();
      logic [15:0] e;
      cs_n = 1'b0; rd_n = 1'b0; cyc(3);
      e = m_read();
      total++; if (db_drive !== 1'b1 || db_i !== e) begin
         bad++; $display("FAIL release_pre: got drv=%b db=%h want 1 %h", db_drive, db_i, e); end
      db_t = 1'b0; cyc(1);
      total++; if (db_drive !== 1'b0) begin bad++; $display("FAIL release_drop: got %b want 0", db_drive); end
      total++; if (db_i !== e) begin bad++; $display("FAIL release_hold: got %h want %h", db_i, e); end
      db_t = 1'b1; rd_n = 1'b1; cyc(3); cs_n = 1'b1; cyc(3);
   endtask

   initial begin
      m_reset();
      test_reset();
      test_conversion();
      test_sample_reads();
      test_register();
      test_overrun_conv_read();
      test_reset_mid_conv();
      test_simultaneous();
      test_db_release();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
